// File: rtl/operand_row_packer_pkg.sv
// ---------------------------------------------------------------------------
// operand_row_packer_pkg
// Constants shared by the operand row packer and the multiplier stage:
// lane count, element widths, rows per frame and the derived bus and
// row-index widths.
// ---------------------------------------------------------------------------
package operand_row_packer_pkg;

  localparam int LANES = 28;  // multiplier lanes per row
  localparam int PIX_W = 10;  // pixel width in bits
  localparam int WT_W  = 19;  // weight width in bits
  localparam int ROWS  = 28;  // rows per frame

  localparam int PIX_BUS_W = LANES * PIX_W;
  localparam int WT_BUS_W  = LANES * WT_W;
  localparam int ROW_IDX_W = $clog2(ROWS);

endpackage

// File: rtl/operand_row_packer_lane_collector.sv
// ---------------------------------------------------------------------------
// lane_collector
// Gathers a serial stream of ELEM_W-bit beats into a LANES-wide vector.
// The n-th accepted beat of a row lands in lane n (lane 0 in the LSBs).
// After the last lane is written the collector reports full and stalls
// its stream until the owner pulses clear.
//
// Ports:
//   clk, GlobalReset  clock, synchronous active-high reset
//   inValid/inData    incoming beat
//   inReady           beat accepted when inValid && inReady
//   clear             empties a full collector (row taken by owner)
//   full              all lanes hold beats of the current row
//   laneData          flattened lane vector
// ---------------------------------------------------------------------------
module lane_collector #(
  parameter int ELEM_W = 10,
  parameter int LANES  = 28
) (
  input  logic                      clk,
  input  logic                      GlobalReset,
  input  logic                      inValid,
  input  logic [ELEM_W-1:0]         inData,
  output logic                      inReady,
  input  logic                      clear,
  output logic                      full,
  output logic [LANES*ELEM_W-1:0]   laneData
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic [LANES-1:0]  laneWe;
  logic [ELEM_W-1:0] lanes [LANES];

  // Ready comes only from the registered full flag, so it never depends on inValid.
  assign inReady = !full && !GlobalReset;
  assign accept  = inValid && inReady;

  // Lane write-enable decode: only the lane selected by the counter is written.
  always_comb begin
    laneWe = {LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      laneWe[k] = accept && (cnt == CNT_W'(k));
    end
  end

  // Lane counter and full flag; accept and clear never coincide since
  // accept needs !full and clear is only issued while full.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      cnt  <= {CNT_W{1'b0}};
      full <= 1'b0;
    end else if (accept) begin
      if (cnt == LAST_LANE) begin
        cnt  <= {CNT_W{1'b0}};
        full <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  // Lane storage; an unselected lane keeps its value.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      for (int k = 0; k < LANES; k++) begin
        lanes[k] <= {ELEM_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (laneWe[k]) begin
          lanes[k] <= inData;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : gFlat
      assign laneData[g*ELEM_W +: ELEM_W] = lanes[g];
    end
  endgenerate

endmodule

// File: rtl/operand_row_packer.sv
// ---------------------------------------------------------------------------
// operand_row_packer
// Producer side of the multiplier operand interface. Two independent
// serial streams (pixels, weights) each fill a lane collector; once both
// are full the pair is copied into the output holding register and
// presented on PixelX/WeightX with a valid/ready handshake, a row index
// and a last-row flag. Collectors may fill the next row while the current
// one is held.
//
// Ports:
//   clk, GlobalReset      clock, synchronous active-high reset
//   pix_valid/pix_data    pixel beat in, pix_ready accepts it
//   wt_valid/wt_data      weight beat in, wt_ready accepts it
//   row_valid/row_ready   output row handshake
//   PixelX, WeightX       lane vectors, lane 0 in the LSBs
//   row_idx, row_last     index of presented row, high on row ROWS-1
// ---------------------------------------------------------------------------
module operand_row_packer
  import operand_row_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 GlobalReset,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  output logic                 pix_ready,
  input  logic                 wt_valid,
  input  logic [WT_W-1:0]      wt_data,
  output logic                 wt_ready,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [PIX_BUS_W-1:0] PixelX,
  output logic [WT_BUS_W-1:0]  WeightX,
  output logic [ROW_IDX_W-1:0] row_idx,
  output logic                 row_last
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

  logic                 pixFull;
  logic                 wtFull;
  logic                 transfer;
  logic [PIX_BUS_W-1:0] pixLanes;
  logic [WT_BUS_W-1:0]  wtLanes;
  logic [ROW_IDX_W-1:0] nextIdx;   // index the next transferred row will carry

  // A new row may enter the holding register when it is empty or being taken this cycle.
  assign transfer = pixFull && wtFull && (!row_valid || row_ready);

  lane_collector #(.ELEM_W(PIX_W), .LANES(LANES)) pixCollector (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .inValid     (pix_valid),
    .inData      (pix_data),
    .inReady     (pix_ready),
    .clear       (transfer),
    .full        (pixFull),
    .laneData    (pixLanes)
  );

  lane_collector #(.ELEM_W(WT_W), .LANES(LANES)) wtCollector (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .inValid     (wt_valid),
    .inData      (wt_data),
    .inReady     (wt_ready),
    .clear       (transfer),
    .full        (wtFull),
    .laneData    (wtLanes)
  );

  // Output holding register and row counter; data only changes on a transfer.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      row_valid <= 1'b0;
      PixelX    <= {PIX_BUS_W{1'b0}};
      WeightX   <= {WT_BUS_W{1'b0}};
      row_idx   <= {ROW_IDX_W{1'b0}};
      row_last  <= 1'b0;
      nextIdx   <= {ROW_IDX_W{1'b0}};
    end else if (transfer) begin
      row_valid <= 1'b1;
      PixelX    <= pixLanes;
      WeightX   <= wtLanes;
      row_idx   <= nextIdx;
      row_last  <= (nextIdx == LAST_ROW);
      if (nextIdx == LAST_ROW) begin
        nextIdx <= {ROW_IDX_W{1'b0}};
      end else begin
        nextIdx <= nextIdx + ROW_IDX_W'(1);
      end
    end else if (row_valid && row_ready) begin
      row_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_row_packer.sv
module tb_operand_row_packer;
  import operand_row_packer_pkg::*;

  logic                 clk = 1'b0;
  logic                 GlobalReset;
  logic                 pix_valid;
  logic [PIX_W-1:0]     pix_data;
  logic                 pix_ready;
  logic                 wt_valid;
  logic [WT_W-1:0]      wt_data;
  logic                 wt_ready;
  logic                 row_valid;
  logic                 row_ready;
  logic [PIX_BUS_W-1:0] PixelX;
  logic [WT_BUS_W-1:0]  WeightX;
  logic [ROW_IDX_W-1:0] row_idx;
  logic                 row_last;

  always #5 clk = ~clk;

  operand_row_packer dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .row_valid(row_valid), .row_ready(row_ready),
    .PixelX(PixelX), .WeightX(WeightX), .row_idx(row_idx), .row_last(row_last)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [PIX_BUS_W-1:0] pix;
    logic [WT_BUS_W-1:0]  wt;
    logic [ROW_IDX_W-1:0] idx;
    logic                 last;
  } row_t;

  logic [PIX_W-1:0] pixQ[$];
  logic [WT_W-1:0]  wtQ[$];
  row_t             expQ[$];
  row_t             monRow;
  int               modelIdx = 0;
  int               rowsSeen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (GlobalReset === 1'b1) begin
        pixQ.delete();
        wtQ.delete();
        expQ.delete();
        modelIdx = 0;
      end else begin
        if (row_valid === 1'b1 && row_ready === 1'b1) begin
          rowsSeen++;
          if (expQ.size() == 0) begin
            chk("sb_row_pending", expQ.size(), 1);
          end else begin
            monRow = expQ.pop_front();
            chk("sb_pixel", PixelX, monRow.pix);
            chk("sb_weight", WeightX, monRow.wt);
            chk("sb_idx", row_idx, monRow.idx);
            chk("sb_last", row_last, monRow.last);
          end
        end
        if (pix_valid && pix_ready) pixQ.push_back(pix_data);
        if (wt_valid && wt_ready) wtQ.push_back(wt_data);
        if (pixQ.size() >= LANES && wtQ.size() >= LANES) begin
          for (int k = 0; k < LANES; k++) begin
            monRow.pix[k*PIX_W +: PIX_W] = pixQ.pop_front();
            monRow.wt[k*WT_W +: WT_W]    = wtQ.pop_front();
          end
          monRow.idx = modelIdx[ROW_IDX_W-1:0];
          monRow.last = (modelIdx == ROWS - 1);
          modelIdx = (modelIdx + 1) % ROWS;
          expQ.push_back(monRow);
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [PIX_W-1:0]     pixBase;
    logic [WT_W-1:0]      wtBase;
    logic [PIX_W-1:0]     expPix0;
    logic [PIX_W-1:0]     expPix27;
    logic [WT_W-1:0]      expWt0;
    logic [WT_W-1:0]      expWt27;
    logic [ROW_IDX_W-1:0] expIdx;
    logic                 expLast;
  } vec_t;

  vec_t vecs[3];
  logic bad;
  int   pcnt, wcnt, rises, lastRise, rowsBefore;
  logic prevRV, pAcc, wAcc;

  initial begin
    vecs[0] = '{10'd1,     19'h40000, 10'd1,     10'd28,    19'h40000, 19'h4001B, 5'd0, 1'b0};
    vecs[1] = '{10'h3F0,   19'h7FFF0, 10'h3F0,   10'h00B,   19'h7FFF0, 19'h0000B, 5'd1, 1'b0};
    vecs[2] = '{10'h200,   19'h12345, 10'h200,   10'h21B,   19'h12345, 19'h12360, 5'd2, 1'b0};

    GlobalReset = 1'b1; pix_valid = 1'b0; wt_valid = 1'b0;
    pix_data = '0; wt_data = '0; row_ready = 1'b1;
    step();
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_wt_ready", wt_ready, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_pixelx", PixelX, 0);
    chk("rst_weightx", WeightX, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_row_last", row_last, 0);
    GlobalReset = 1'b0;
    #1;
    chk("ready_after_rst", {pix_ready, wt_ready}, 2'b11);

    // Table-driven full rows, row_ready held high.
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < LANES; j++) begin
        pix_valid = 1'b1; pix_data = vecs[v].pixBase + PIX_W'(j);
        wt_valid  = 1'b1; wt_data  = vecs[v].wtBase + WT_W'(j);
        step();
      end
      pix_valid = 1'b0; wt_valid = 1'b0;
      chk("vec_not_yet_valid", row_valid, 0);
      chk("vec_pix_full_stall", pix_ready, 0);
      step();
      chk("vec_row_valid", row_valid, 1);
      chk("vec_pix_lane0", PixelX[0 +: PIX_W], vecs[v].expPix0);
      chk("vec_pix_lane27", PixelX[27*PIX_W +: PIX_W], vecs[v].expPix27);
      chk("vec_wt_lane0", WeightX[0 +: WT_W], vecs[v].expWt0);
      chk("vec_wt_lane27", WeightX[27*WT_W +: WT_W], vecs[v].expWt27);
      chk("vec_row_idx", row_idx, vecs[v].expIdx);
      chk("vec_row_last", row_last, vecs[v].expLast);
      chk("vec_ready_back", {pix_ready, wt_ready}, 2'b11);
      step();
      chk("vec_single_pulse", row_valid, 0);
    end

    // Pixels finish while weights stall after 10 beats (row 3).
    for (int j = 0; j < LANES; j++) begin
      pix_valid = 1'b1; pix_data = PIX_W'(100 + j);
      wt_valid = (j < 10); wt_data = WT_W'(32'h1000 + j);
      step();
    end
    pix_data = 10'd999;
    chk("stall_pix_ready_low", pix_ready, 0);
    bad = 1'b0;
    for (int j = 10; j < LANES; j++) begin
      wt_valid = 1'b1; wt_data = WT_W'(32'h1000 + j);
      if (pix_ready !== 1'b0 || row_valid !== 1'b0) bad = 1'b1;
      step();
    end
    pix_valid = 1'b0; wt_valid = 1'b0;
    chk("stall_held_off", bad, 0);
    chk("stall_not_yet_valid", row_valid, 0);
    step();
    chk("stall_row_valid", row_valid, 1);
    chk("stall_pix_ready_back", pix_ready, 1);
    chk("stall_row_idx", row_idx, 3);
    chk("stall_pix_lane27", PixelX[27*PIX_W +: PIX_W], 127);
    step();

    // Hold row 4 with row_ready low while row 5 fills behind it.
    row_ready = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      pix_valid = 1'b1; pix_data = PIX_W'(200 + j);
      wt_valid = 1'b1; wt_data = WT_W'(32'h2000 + j);
      step();
    end
    pix_valid = 1'b0; wt_valid = 1'b0;
    step();
    chk("hold_row4_valid", row_valid, 1);
    for (int j = 0; j < LANES; j++) begin
      pix_valid = 1'b1; pix_data = PIX_W'(300 + j);
      wt_valid = 1'b1; wt_data = WT_W'(32'h3000 + j);
      step();
    end
    pix_valid = 1'b0; wt_valid = 1'b0;
    chk("hold_readys_low", {pix_ready, wt_ready}, 2'b00);
    step(); step();
    chk("hold_valid", row_valid, 1);
    chk("hold_idx", row_idx, 4);
    chk("hold_pix_lane0", PixelX[0 +: PIX_W], 200);
    chk("hold_pix_lane27", PixelX[27*PIX_W +: PIX_W], 227);
    chk("hold_wt_lane0", WeightX[0 +: WT_W], 32'h2000);
    row_ready = 1'b1;
    step();
    row_ready = 1'b0;
    chk("swap_valid", row_valid, 1);
    chk("swap_idx", row_idx, 5);
    chk("swap_pix_lane0", PixelX[0 +: PIX_W], 300);
    chk("swap_wt_lane27", WeightX[27*WT_W +: WT_W], 32'h301B);
    chk("swap_readys_back", {pix_ready, wt_ready}, 2'b11);
    row_ready = 1'b1;
    step();
    chk("swap_drained", row_valid, 0);

    // Mid-row reset after 15 beats.
    for (int j = 0; j < 15; j++) begin
      pix_valid = 1'b1; pix_data = PIX_W'(400 + j);
      wt_valid = 1'b1; wt_data = WT_W'(32'h4000 + j);
      step();
    end
    pix_valid = 1'b0; wt_valid = 1'b0;
    GlobalReset = 1'b1;
    #1;
    chk("midrst_readys_low", {pix_ready, wt_ready}, 2'b00);
    step();
    chk("midrst_pixelx", PixelX, 0);
    chk("midrst_weightx", WeightX, 0);
    chk("midrst_row_idx", row_idx, 0);
    chk("midrst_valid_last", {row_valid, row_last}, 2'b00);
    GlobalReset = 1'b0;
    #1;

    // Fresh row plus 28 back-to-back rows.
    pcnt = 0; wcnt = 0; rises = 0; lastRise = -1; prevRV = 1'b0;
    row_ready = 1'b1;
    for (int cyc = 0; cyc < 29*29 + 40 && rises < 29; cyc++) begin
      pix_valid = (pcnt < 29*LANES); pix_data = PIX_W'(pcnt*7 + 5);
      wt_valid  = (wcnt < 29*LANES); wt_data  = WT_W'(wcnt*3 + 32'h100);
      pAcc = pix_valid && pix_ready;
      wAcc = wt_valid && wt_ready;
      step();
      if (pAcc) pcnt++;
      if (wAcc) wcnt++;
      if (row_valid && !prevRV) begin
        chk("b2b_idx", row_idx, rises % ROWS);
        chk("b2b_last", row_last, ((rises % ROWS) == ROWS - 1));
        if (rises == 0) begin
          chk("fresh_lane0", PixelX[0 +: PIX_W], 5);
          chk("fresh_lane27", PixelX[27*PIX_W +: PIX_W], 194);
          chk("fresh_wt_lane0", WeightX[0 +: WT_W], 32'h100);
        end else begin
          chk("b2b_interval", cyc - lastRise, 29);
        end
        lastRise = cyc;
        rises++;
      end
      prevRV = row_valid;
    end
    chk("b2b_rows", rises, 29);
    pix_valid = 1'b0; wt_valid = 1'b0;
    step(); step();

    // Random gaps on both streams against random row_ready.
    rowsBefore = rowsSeen;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      pix_valid = ($urandom_range(0, 3) != 0); pix_data = PIX_W'($urandom);
      wt_valid  = ($urandom_range(0, 3) != 0); wt_data  = WT_W'($urandom);
      row_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    pix_valid = 1'b0; wt_valid = 1'b0; row_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rand_all_delivered", expQ.size(), 0);
    chk("rand_progress", (rowsSeen - rowsBefore) >= 10, 1);
    chk("rand_idle", row_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
